// File: rtl/ofifo_drain.sv
// ---------------------------------------------------------------------------
// ofifo_drain
//
// Read-side controller for the output FIFO bank. Each drain pops num_rows
// full rows (col lanes of bw bits) from the ofifo and writes row k to the
// psum SRAM at base_addr + k, modulo 2**addr_w. The pacing assumes the
// ofifo has a registered read path, so data appears one cycle after rd.
//
// Parameters
//   col     lanes per row (matches ofifo col)
//   bw      bits per lane (matches ofifo bw)
//   addr_w  SRAM address width; also the width of the row counter
//
// Ports
//   clk         single clock, all logic on posedge
//   reset       synchronous, active-low (0 = reset)
//   start       1-cycle pulse: begin a drain of num_rows rows (ignored if busy)
//   num_rows    rows to drain, sampled on an accepted start
//   base_addr   first SRAM address, sampled on an accepted start
//   fifo_valid  ofifo o_valid: every lane holds at least one entry
//   fifo_rd     ofifo rd: 1-cycle pop request
//   fifo_out    ofifo read data, lane i at [bw*(i+1)-1 : bw*i]
//   sram_cen    SRAM chip enable, active-low
//   sram_wen    SRAM write enable, active-low
//   sram_addr   SRAM address
//   sram_d      SRAM write data, same lane layout as fifo_out
//   busy        high from an accepted start until done
//   done        1-cycle pulse after the last row has been written
//
// Build option
//   DRAIN_RELU_EN  when defined, each lane is treated as signed two's
//                  complement and negative lanes are written as zero.
//                  When undefined, lanes are written bit-exact.
//
// Every output is driven straight from a flop, so the SRAM and ofifo see
// clean registered signals.
// ---------------------------------------------------------------------------
module ofifo_drain #(
    parameter int col    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_w-1:0]     num_rows,
    input  logic [addr_w-1:0]     base_addr,
    input  logic                  fifo_valid,
    output logic                  fifo_rd,
    input  logic [col*bw-1:0]     fifo_out,
    output logic                  sram_cen,
    output logic                  sram_wen,
    output logic [addr_w-1:0]     sram_addr,
    output logic [col*bw-1:0]     sram_d,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD,
        S_CAP,
        S_SETTLE,
        S_FIN
    } state_t;

    state_t              state_q,     state_d;
    logic [addr_w-1:0]   num_rows_q,  num_rows_d;
    logic [addr_w-1:0]   base_q,      base_d;
    logic [addr_w-1:0]   cnt_q,       cnt_d;
    logic                fifo_rd_q,   fifo_rd_d;
    logic                sram_cen_q,  sram_cen_d;
    logic                sram_wen_q,  sram_wen_d;
    logic [addr_w-1:0]   sram_addr_q, sram_addr_d;
    logic [col*bw-1:0]   sram_d_q,    sram_d_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;

    // Lane filter applied between the captured ofifo row and the write-data
    // register. Purely combinational, so it adds no latency.
    function automatic logic [col*bw-1:0] lane_filter(input logic [col*bw-1:0] row);
        logic [col*bw-1:0] res;
        res = row;
`ifdef DRAIN_RELU_EN
        for (int i = 0; i < col; i++) begin
            // Sign bit of the lane set -> negative -> clamp to zero.
            if (row[bw*(i+1)-1]) begin
                res[bw*i +: bw] = '0;
            end
        end
`endif
        return res;
    endfunction

    // Next-state and output decode.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        num_rows_d  = num_rows_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        sram_cen_d  = 1'b1;
        sram_wen_d  = 1'b1;
        sram_addr_d = sram_addr_q;
        sram_d_d    = sram_d_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_rows_d = num_rows;
                    base_d     = base_addr;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = (num_rows == '0) ? S_FIN : S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == num_rows_q) begin
                    state_d = S_FIN;
                end else if (fifo_valid) begin
                    state_d = S_RD;
                end
            end

            // fifo_rd is high during this state; the row arrives next cycle.
            S_RD: begin
                state_d = S_CAP;
            end

            // Capture the popped row and register the SRAM write; the write
            // is on the pins during the following (SETTLE) cycle.
            S_CAP: begin
                sram_cen_d  = 1'b0;
                sram_wen_d  = 1'b0;
                sram_addr_d = base_q + cnt_q;   // wraps modulo 2**addr_w
                sram_d_d    = lane_filter(fifo_out);
                cnt_d       = cnt_q + 1'b1;
                state_d     = S_SETTLE;
            end

            // By now fifo_valid reflects the pop issued in RD, so this cycle
            // can make the same decision WAIT would. Going straight back to RD
            // when the next row is ready keeps the rate at one row per three
            // cycles; WAIT is only revisited when the ofifo runs dry.
            S_SETTLE: begin
                if (cnt_q == num_rows_q) begin
                    state_d = S_FIN;
                end else if (fifo_valid) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_WAIT;
                end
            end

            // done and the busy drop both appear on the cycle after FIN.
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered pop request: high exactly while the FSM sits in RD.
        fifo_rd_d = (state_d == S_RD);
    end

    // State and output registers with synchronous active-low reset. A reset
    // mid-drain abandons the remaining rows.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q     <= S_IDLE;
            num_rows_q  <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            fifo_rd_q   <= 1'b0;
            sram_cen_q  <= 1'b1;
            sram_wen_q  <= 1'b1;
            sram_addr_q <= '0;
            sram_d_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_rows_q  <= num_rows_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            fifo_rd_q   <= fifo_rd_d;
            sram_cen_q  <= sram_cen_d;
            sram_wen_q  <= sram_wen_d;
            sram_addr_q <= sram_addr_d;
            sram_d_q    <= sram_d_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fifo_rd   = fifo_rd_q;
    assign sram_cen  = sram_cen_q;
    assign sram_wen  = sram_wen_q;
    assign sram_addr = sram_addr_q;
    assign sram_d    = sram_d_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ofifo_drain.sv
// ---------------------------------------------------------------------------
// tb_ofifo_drain
//
// Directed bench for ofifo_drain (col=8, bw=4, addr_w=11). A small ofifo
// model returns queued rows one cycle after fifo_rd; a negedge logger records
// SRAM writes, pop cycles and done pulses, and each scenario compares that
// log with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_ofifo_drain;

    localparam int COL = 8;
    localparam int BW  = 4;
    localparam int AW  = 11;
    localparam int DW  = COL * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] num_rows;
    logic [AW-1:0] base_addr;
    logic          fifo_valid;
    logic          fifo_rd;
    logic [DW-1:0] fifo_out;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_d;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    ofifo_drain #(.col(COL), .bw(BW), .addr_w(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_rows   (num_rows),
        .base_addr  (base_addr),
        .fifo_valid (fifo_valid),
        .fifo_rd    (fifo_rd),
        .fifo_out   (fifo_out),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_d     (sram_d),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ofifo model: rows[] queued, avail of them currently present.
    logic [DW-1:0] rows[$];
    int            rd_idx;
    int            avail;
    logic          valid_en;

    assign fifo_valid = valid_en && (rd_idx < avail);

    // Log of observed activity.
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            rd_cyc[$];
    int            n_done;
    int            n_cenwen_bad;
    int            n_underflow;
    int            cyc;

    always @(negedge clk) begin
        cyc++;
        if (sram_cen === 1'b0) begin
            wr_addr.push_back(sram_addr);
            wr_data.push_back(sram_d);
        end
        if (sram_cen !== sram_wen) n_cenwen_bad++;
        if (done === 1'b1) n_done++;
        if (fifo_rd === 1'b1) begin
            if (!fifo_valid) n_underflow++;
            rd_cyc.push_back(cyc);
            if (rd_idx < rows.size()) fifo_out = rows[rd_idx];
            rd_idx++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        rd_cyc.delete();
        n_done = 0;
    endtask

    task automatic load_rows(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                             input logic [DW-1:0] r2, input int n_avail);
        rows     = '{r0, r1, r2};
        rd_idx   = 0;
        avail    = n_avail;
        valid_en = 1'b1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] n, input logic [AW-1:0] b);
        start     = 1'b1;
        num_rows  = n;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        tick(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fifo_rd"},   fifo_rd,   1'b0);
        check({tag, "_sram_cen"},  sram_cen,  1'b1);
        check({tag, "_sram_wen"},  sram_wen,  1'b1);
        check({tag, "_sram_addr"}, sram_addr, '0);
        check({tag, "_sram_d"},    sram_d,    '0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_done"},      done,      1'b0);
    endtask

    localparam logic [DW-1:0] ROW_A = 32'h1234_5670;
    localparam logic [DW-1:0] ROW_B = 32'h0765_4321;
    localparam logic [DW-1:0] ROW_C = 32'h7777_0000;
    localparam logic [DW-1:0] ROW_D = 32'h1111_1111;
    localparam logic [DW-1:0] ROW_E = 32'h2222_2222;
    localparam logic [DW-1:0] ROW_F = 32'h3030_3030;
    localparam logic [DW-1:0] ROW_G = 32'h0404_0404;
    localparam logic [DW-1:0] ROW_H = 32'h0600_0060;
    // Lanes 3..0 = 8,7,F,1; upper lanes 5,A,3,C.
    localparam logic [DW-1:0] ROW_R = 32'h5A3C_87F1;
`ifdef DRAIN_RELU_EN
    localparam logic [DW-1:0] EXP_R = 32'h5030_0701;
`else
    localparam logic [DW-1:0] EXP_R = 32'h5A3C_87F1;
`endif

    int rd_before;

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        num_rows  = '0;
        base_addr = '0;
        fifo_out  = '0;
        valid_en  = 1'b0;
        rd_idx    = 0;
        avail     = 0;
        cyc       = 0;
        n_cenwen_bad = 0;
        n_underflow  = 0;
        clear_log();

        // Reset values.
        tick(2);
        check_reset_outputs("por");
        reset = 1'b1;
        tick(1);

        // Three rows at 0x010 with valid held high; a mid-drain start is ignored.
        clear_log();
        load_rows(ROW_A, ROW_B, ROW_C, 3);
        pulse_start(11'd3, 11'h010);
        check("t2_busy_after_start", busy, 1'b1);
        tick(4);
        pulse_start(11'd7, 11'h300);
        wait_done(60, "t2");
        check("t2_n_writes", wr_addr.size(), 3);
        check("t2_addr0", wr_addr[0], 11'h010);
        check("t2_data0", wr_data[0], ROW_A);
        check("t2_addr1", wr_addr[1], 11'h011);
        check("t2_data1", wr_data[1], ROW_B);
        check("t2_addr2", wr_addr[2], 11'h012);
        check("t2_data2", wr_data[2], ROW_C);
        check("t2_n_rd", rd_cyc.size(), 3);
        if (rd_cyc.size() == 3) begin
            check("t2_rd_gap01", rd_cyc[1] - rd_cyc[0], 3);
            check("t2_rd_gap12", rd_cyc[2] - rd_cyc[1], 3);
        end
        check("t2_n_done", n_done, 1);
        check("t2_busy_after_done", busy, 1'b0);
        tick(10);
        check("t2_no_extra_writes", wr_addr.size(), 3);

        // ofifo runs dry after row 1: FSM stalls, row 2 follows when valid returns.
        clear_log();
        load_rows(ROW_D, ROW_E, '0, 1);
        pulse_start(11'd2, 11'h100);
        tick(6);
        check("t3_rd_before_stall", rd_cyc.size(), 1);
        check("t3_writes_before_stall", wr_addr.size(), 1);
        tick(10);
        check("t3_rd_during_stall", rd_cyc.size(), 1);
        check("t3_fifo_rd_low", fifo_rd, 1'b0);
        check("t3_busy_stalled", busy, 1'b1);
        avail = 2;
        wait_done(40, "t3");
        check("t3_n_writes", wr_addr.size(), 2);
        check("t3_addr0", wr_addr[0], 11'h100);
        check("t3_data0", wr_data[0], ROW_D);
        check("t3_addr1", wr_addr[1], 11'h101);
        check("t3_data1", wr_data[1], ROW_E);

        // Address wrap at the top of the SRAM.
        clear_log();
        load_rows(ROW_F, ROW_G, '0, 2);
        pulse_start(11'd2, 11'h7FF);
        wait_done(40, "t4");
        check("t4_n_writes", wr_addr.size(), 2);
        check("t4_addr0", wr_addr[0], 11'h7FF);
        check("t4_data0", wr_data[0], ROW_F);
        check("t4_addr1", wr_addr[1], 11'h000);
        check("t4_data1", wr_data[1], ROW_G);

        // Zero-row drain: straight to FIN; second start while busy is ignored.
        clear_log();
        load_rows(ROW_A, ROW_B, '0, 2);
        pulse_start(11'd0, 11'h055);
        check("t5_busy_in_fin", busy, 1'b1);
        check("t5_done_in_fin", done, 1'b0);
        start     = 1'b1;
        num_rows  = 11'd4;
        base_addr = 11'h066;
        @(negedge clk);
        start = 1'b0;
        check("t5_done_pulse", done, 1'b1);
        check("t5_busy_low", busy, 1'b0);
        tick(1);
        check("t5_done_single", done, 1'b0);
        tick(10);
        check("t5_no_rd", rd_cyc.size(), 0);
        check("t5_no_writes", wr_addr.size(), 0);
        check("t5_idle_busy", busy, 1'b0);
        check("t5_cen_high", sram_cen, 1'b1);

        // Reset held for two cycles mid-drain.
        clear_log();
        load_rows(ROW_A, ROW_B, ROW_C, 3);
        pulse_start(11'd3, 11'h200);
        tick(5);
        reset = 1'b0;
        tick(2);
        check_reset_outputs("t1_mid");
        rd_before = rd_cyc.size();
        reset = 1'b1;
        tick(12);
        check("t1_no_rd_after", rd_cyc.size(), rd_before);
        check("t1_busy_after", busy, 1'b0);
        check("t1_no_done", n_done, 0);
        // A fresh one-row drain must start counting from zero.
        clear_log();
        load_rows(ROW_H, '0, '0, 1);
        pulse_start(11'd1, 11'h020);
        wait_done(30, "t1");
        check("t1_n_writes", wr_addr.size(), 1);
        check("t1_addr0", wr_addr[0], 11'h020);
        check("t1_data0", wr_data[0], ROW_H);

        // Lane filter on signed lanes.
        clear_log();
        load_rows(ROW_R, '0, '0, 1);
        pulse_start(11'd1, 11'h3A0);
        wait_done(30, "t6");
        check("t6_n_writes", wr_addr.size(), 1);
        check("t6_addr0", wr_addr[0], 11'h3A0);
        check("t6_data0", wr_data[0], EXP_R);

        check("cen_wen_together", n_cenwen_bad, 0);
        check("no_underflow", n_underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
